wb_intercon_n: RTL and testbench
================================

# wb_intercon_n

Parametrised single-master Wishbone shared-bus interconnect for the moxie SoC. It connects the CPU data master to 1–8 slaves through a registered address decoder and a per-slave strobe/cycle fan-out. Read data is muxed from the granted slave only. Unmapped addresses and stalled slaves are converted into a one-cycle bus error instead of hanging the master.

## Interface
Parameters:
- NSLAVES, 4, number of slave ports (1–8).
- AW, 32, address width.
- DW, 32, data width.
- SELW, 4, byte-select width.
- SLAVE_ADDR, 0, packed NSLAVES×AW base addresses; slave i occupies bits [i*AW +: AW].
- SLAVE_MASK, 0, packed NSLAVES×AW decode masks, same packing.
- TIMEOUT, 255, cycles to wait for slave ack before error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all logic is on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- wbm_adr_i  in  AW  master address.
- wbm_dat_i  in  DW  master write data.
- wbm_sel_i  in  SELW  master byte selects.
- wbm_we_i  in  1  master write enable.
- wbm_cyc_i  in  1  master cycle.
- wbm_stb_i  in  1  master strobe.
- wbm_dat_o  out  DW  read data from the granted slave.
- wbm_ack_o  out  1  transfer acknowledge.
- wbm_err_o  out  1  transfer error (unmapped address or timeout).
- wbs_adr_o  out  AW  shared address to all slaves, equal to wbm_adr_i.
- wbs_dat_o  out  DW  shared write data, equal to wbm_dat_i.
- wbs_sel_o  out  SELW  shared byte selects, equal to wbm_sel_i.
- wbs_we_o  out  1  shared write enable, equal to wbm_we_i.
- wbs_cyc_o  out  NSLAVES  per-slave cycle.
- wbs_stb_o  out  NSLAVES  per-slave strobe.
- wbs_dat_i  in  NSLAVES×DW  packed slave read data.
- wbs_ack_i  in  NSLAVES  per-slave acknowledge.

## Operation
- Decode: slave i matches when (wbm_adr_i & SLAVE_MASK[i]) == SLAVE_ADDR[i]. Among multiple matches, the lowest index wins.
- The FSM has three states: IDLE, ACTIVE and ERROR. A one-hot grant register is NSLAVES wide, and a timeout counter is 16 bits wide.
- IDLE:
  - On wbm_cyc_i & wbm_stb_i with a match: load grant with the winning slave, clear the counter, go to ACTIVE.
  - On wbm_cyc_i & wbm_stb_i with no match: go to ERROR.
  - Otherwise stay in IDLE.
- ACTIVE:
  - wbs_cyc_o[i] = grant[i] & wbm_cyc_i.
  - wbs_stb_o[i] = grant[i] & wbm_cyc_i & wbm_stb_i.
  - wbm_ack_o = |(wbs_ack_i & grant), combinational pass-through. Acks from non-granted slaves are ignored.
  - wbm_dat_o = wbs_dat_i of the granted slave. In every other state wbm_dat_o = 0.
  - On a granted ack: go to IDLE and clear grant.
  - If wbm_cyc_i drops: go to IDLE and clear grant, with no ack or err to the master.
  - Otherwise the counter increments. When TIMEOUT != 0 and the counter equals TIMEOUT-1 with no ack: assert wbm_err_o this cycle, drop the slave strobe next cycle, go to IDLE.
- ERROR: assert wbm_err_o for exactly one cycle, then go to IDLE. No slave strobe is asserted.
- wbm_ack_o and wbm_err_o are never high together. If an ack arrives on the timeout cycle, ack wins and err stays low.
- Shared adr/dat/sel/we are continuous pass-through, independent of state.

## Timing
- Reset: state IDLE; grant 0; counter 0; wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_cyc_o and wbs_stb_o all 0.
- Reset asserted mid-transfer aborts the transfer: outputs take reset values on the next edge, and no ack or err is issued.
- Latency: master strobe in cycle N (IDLE) gives slave strobe in cycle N+1. With a zero-wait slave that acks combinationally, wbm_ack_o is high in N+1. Minimum two cycles per transfer.
- Back-to-back transfers: FSM is IDLE in the cycle after an ack. If the master still holds stb, that cycle decodes the next transfer. Throughput is one transfer per two cycles.
- Unmapped access: strobe in N gives wbm_err_o in N+1 only.
- Timeout: with TIMEOUT = T, the first ACTIVE cycle is N+1 and wbm_err_o is high in cycle N+T.
- The master must hold adr, we and stb stable until ack or err (classic Wishbone). Decode is not re-evaluated while ACTIVE.

## Test plan
- NSLAVES=4, slave1 at 0x1000_0000 mask 0xF000_0000, zero-wait. Read 0x1000_0004 with slave1 data 0xDEADBEEF: wbs_stb_o=4'b0010 in N+1; wbm_ack_o=1 and wbm_dat_o=0xDEADBEEF in N+1.
- Overlapping decode, slaves 0 and 2 both match 0x0000_0010: only wbs_stb_o[0] asserts. A spurious wbs_ack_i[2] pulse gives no wbm_ack_o.
- Access to unmapped 0x8000_0000: wbm_err_o high for exactly cycle N+1; all wbs_stb_o stay 0; FSM IDLE at N+2.
- TIMEOUT=8, slave never acks: wbm_err_o high only in cycle N+8; wbs_stb_o low from N+9. Repeat with ack in cycle N+8: ack=1, err=0.
- Master drops wbm_cyc_i in the second ACTIVE cycle: no ack or err; wbs_cyc_o=0 next cycle; a following access completes normally.
- rst_i asserted during ACTIVE with a 3-wait slave: all outputs 0 on the next edge. The late slave ack is ignored, and the next access behaves as after reset.

Source files
------------

// File: rtl/wb_intercon_n.sv
// wb_intercon_n: single-master Wishbone shared-bus interconnect with registered decode,
// one-hot grant, per-slave cyc/stb fan-out and unmapped/timeout bus errors.
module wb_intercon_n #(
    parameter int                    NSLAVES    = 4,
    parameter int                    AW         = 32,
    parameter int                    DW         = 32,
    parameter int                    SELW       = 4,
    parameter logic [NSLAVES*AW-1:0] SLAVE_ADDR = '0,
    parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AW-1:0]         wbm_adr_i,
    input  logic [DW-1:0]         wbm_dat_i,
    input  logic [SELW-1:0]       wbm_sel_i,
    input  logic                  wbm_we_i,
    input  logic                  wbm_cyc_i,
    input  logic                  wbm_stb_i,
    output logic [DW-1:0]         wbm_dat_o,
    output logic                  wbm_ack_o,
    output logic                  wbm_err_o,
    output logic [AW-1:0]         wbs_adr_o,
    output logic [DW-1:0]         wbs_dat_o,
    output logic [SELW-1:0]       wbs_sel_o,
    output logic                  wbs_we_o,
    output logic [NSLAVES-1:0]    wbs_cyc_o,
    output logic [NSLAVES-1:0]    wbs_stb_o,
    input  logic [NSLAVES*DW-1:0] wbs_dat_i,
    input  logic [NSLAVES-1:0]    wbs_ack_i
);
    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t             state_q;
    logic [NSLAVES-1:0] grant_q, match_d;
    logic [15:0]        cnt_q;
    logic [DW-1:0]      dat_d;
    logic               req, tmo;

    // Descending scan so the lowest matching index overrides the rest.
    always_comb begin
        match_d = '0;
        for (int i = NSLAVES - 1; i >= 0; i--)
            if ((wbm_adr_i & SLAVE_MASK[i*AW +: AW]) == SLAVE_ADDR[i*AW +: AW]) begin
                match_d    = '0;
                match_d[i] = 1'b1;
            end
    end

    // Grant is only non-zero while ACTIVE, so the AND-OR mux reads 0 elsewhere.
    always_comb begin
        dat_d = '0;
        for (int i = 0; i < NSLAVES; i++)
            dat_d |= grant_q[i] ? wbs_dat_i[i*DW +: DW] : '0;
    end

    assign req       = wbm_cyc_i & wbm_stb_i;
    assign wbm_ack_o = |(wbs_ack_i & grant_q);
    assign tmo       = (TIMEOUT != 0) && state_q == ACTIVE && wbm_cyc_i && cnt_q == TO_LAST && !wbm_ack_o;
    assign wbm_err_o = state_q == ERROR || tmo;
    assign wbm_dat_o = dat_d;
    assign wbs_cyc_o = grant_q & {NSLAVES{wbm_cyc_i}};
    assign wbs_stb_o = wbs_cyc_o & {NSLAVES{wbm_stb_i}};
    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_sel_o = wbm_sel_i;
    assign wbs_we_o  = wbm_we_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    state_q <= |match_d ? ACTIVE : ERROR;
                    grant_q <= match_d;
                    cnt_q   <= '0;
                end
                ACTIVE: if (wbm_ack_o || !wbm_cyc_i || tmo) begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_intercon_n.sv
// tb_wb_intercon_n: scoreboard bench for wb_intercon_n with four slaves and an 8-cycle timeout.
module tb_wb_intercon_n;
    localparam int NS = 4, AW = 32, DW = 32, SELW = 4, TO = 8;
    localparam logic [NS*AW-1:0] SA = {32'h2000_0000, 32'h0000_0010, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] SM = {32'hF000_0000, 32'hFFFF_FFF0, 32'hF000_0000, 32'hF000_0000};

    logic clk = 1'b0, rst = 1'b1;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] dat = '0;
    logic [SELW-1:0] sel = '0;
    logic we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [DW-1:0] wbm_dat_o;
    logic wbm_ack_o, wbm_err_o, wbs_we_o;
    logic [AW-1:0] wbs_adr_o;
    logic [DW-1:0] wbs_dat_o;
    logic [SELW-1:0] wbs_sel_o;
    logic [NS-1:0] wbs_cyc_o, wbs_stb_o, wbs_ack_i;
    logic [NS*DW-1:0] wbs_dat_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0A0A};
    logic [NS-1:0] auto_ack = '0, man_ack = '0;
    logic [32:0] exp_q[$];
    int checks = 0, failures = 0;

    assign wbs_ack_i = (wbs_stb_o & auto_ack) | man_ack;

    wb_intercon_n #(.NSLAVES(NS), .AW(AW), .DW(DW), .SELW(SELW),
                    .SLAVE_ADDR(SA), .SLAVE_MASK(SM), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we),
        .wbm_cyc_i(cyc), .wbm_stb_i(stb),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i)
    );

    always #5 clk = ~clk;

    // Scoreboard: every master-side response pops the oldest expected {err, data}.
    always @(negedge clk) begin
        if (wbm_ack_o === 1'b1 || wbm_err_o === 1'b1) begin
            logic [32:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected ack=%b err=%b expected no response", wbm_ack_o, wbm_err_o);
            end else begin
                e = exp_q.pop_front();
                if (wbm_ack_o === wbm_err_o || wbm_err_o !== e[32] || (!e[32] && wbm_dat_o !== e[31:0])) begin
                    failures++;
                    $display("FAIL sb_response ack=%b err=%b dat=%h expected err=%b dat=%h",
                             wbm_ack_o, wbm_err_o, wbm_dat_o, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        @(negedge clk);
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b err=%b dat=%h cyc=%b stb=%b expected all 0",
                     wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o);
        end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_read;
        auto_ack = 4'b0010;
        tick;
        adr = 32'h1000_0004; dat = 32'h5555_AAAA; sel = 4'hA; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 4'b0000 || wbm_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL read_cycleN stb=%b ack=%b expected 0000 0", wbs_stb_o, wbm_ack_o);
        end
        checks++;
        if (wbs_adr_o !== 32'h1000_0004 || wbs_dat_o !== 32'h5555_AAAA || wbs_sel_o !== 4'hA || wbs_we_o !== 1'b0) begin
            failures++;
            $display("FAIL passthru adr=%h dat=%h sel=%h we=%b expected 10000004 5555aaaa a 0",
                     wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o);
        end
        tick;
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 4'b0010 || wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL read_cycleN1 stb=%b ack=%b dat=%h expected 0010 1 deadbeef", wbs_stb_o, wbm_ack_o, wbm_dat_o);
        end
        tick;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 4'b0000 || wbm_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL read_after stb=%b ack=%b expected 0000 0", wbs_stb_o, wbm_ack_o);
        end
        auto_ack = '0;
    endtask

    task automatic test_back_to_back;
        auto_ack = 4'b1010;
        tick;
        adr = 32'h1000_0008; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        tick;
        @(negedge clk);
        checks++;
        if (wbm_ack_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first ack=%b expected 1", wbm_ack_o);
        end
        tick;
        adr = 32'h2000_0000; we = 1'b1;
        exp_q.push_back({1'b0, 32'h3333_3333});
        @(negedge clk);
        checks++;
        if (wbm_ack_o !== 1'b0 || wbs_stb_o !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_gap ack=%b stb=%b expected 0 0000", wbm_ack_o, wbs_stb_o);
        end
        tick;
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 4'b1000 || wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'h3333_3333 || wbs_we_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second stb=%b ack=%b dat=%h we=%b expected 1000 1 33333333 1",
                     wbs_stb_o, wbm_ack_o, wbm_dat_o, wbs_we_o);
        end
        tick;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; auto_ack = '0;
    endtask

    task automatic test_overlap;
        tick;
        adr = 32'h0000_0010; cyc = 1'b1; stb = 1'b1;
        tick;
        man_ack = 4'b0100;
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 4'b0001 || wbm_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL overlap_grant stb=%b ack=%b expected 0001 0", wbs_stb_o, wbm_ack_o);
        end
        tick;
        man_ack = 4'b0001;
        exp_q.push_back({1'b0, 32'h0000_0A0A});
        @(negedge clk);
        checks++;
        if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'h0000_0A0A) begin
            failures++;
            $display("FAIL overlap_ack ack=%b dat=%h expected 1 00000a0a", wbm_ack_o, wbm_dat_o);
        end
        tick;
        man_ack = '0; cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_unmapped;
        tick;
        adr = 32'h8000_0000; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back({1'b1, 32'h0});
        @(negedge clk);
        checks++;
        if (wbm_err_o !== 1'b0) begin
            failures++;
            $display("FAIL unmapped_cycleN err=%b expected 0", wbm_err_o);
        end
        tick;
        @(negedge clk);
        checks++;
        if (wbm_err_o !== 1'b1 || wbs_stb_o !== 4'b0000 || wbs_cyc_o !== 4'b0000 || wbm_dat_o !== '0) begin
            failures++;
            $display("FAIL unmapped_err err=%b stb=%b cyc=%b dat=%h expected 1 0000 0000 0",
                     wbm_err_o, wbs_stb_o, wbs_cyc_o, wbm_dat_o);
        end
        tick;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        checks++;
        if (wbm_err_o !== 1'b0 || wbs_stb_o !== 4'b0000) begin
            failures++;
            $display("FAIL unmapped_after err=%b stb=%b expected 0 0000", wbm_err_o, wbs_stb_o);
        end
    endtask

    task automatic test_timeout;
        tick;
        adr = 32'h2000_0000; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back({1'b1, 32'h0});
        for (int k = 1; k <= 9; k++) begin
            tick;
            if (k == 9) begin cyc = 1'b0; stb = 1'b0; end
            @(negedge clk);
            checks++;
            if (wbm_err_o !== (k == 8) || wbm_ack_o !== 1'b0 || wbs_stb_o !== (k <= 8 ? 4'b1000 : 4'b0000)) begin
                failures++;
                $display("FAIL timeout_k%0d err=%b ack=%b stb=%b expected %b 0 %b",
                         k, wbm_err_o, wbm_ack_o, wbs_stb_o, k == 8, k <= 8 ? 4'b1000 : 4'b0000);
            end
        end
        tick;
        cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (k == 8) begin
                man_ack = 4'b1000;
                exp_q.push_back({1'b0, 32'h3333_3333});
            end
            @(negedge clk);
            checks++;
            if (wbm_ack_o !== (k == 8) || wbm_err_o !== 1'b0) begin
                failures++;
                $display("FAIL timeout_ack_k%0d ack=%b err=%b expected %b 0", k, wbm_ack_o, wbm_err_o, k == 8);
            end
        end
        tick;
        man_ack = '0; cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_cyc_drop;
        tick;
        adr = 32'h1000_0000; cyc = 1'b1; stb = 1'b1;
        tick;
        @(negedge clk);
        checks++;
        if (wbs_cyc_o !== 4'b0010) begin
            failures++;
            $display("FAIL drop_active cyc=%b expected 0010", wbs_cyc_o);
        end
        tick;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        checks++;
        if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_resp ack=%b err=%b expected 0 0", wbm_ack_o, wbm_err_o);
        end
        tick;
        @(negedge clk);
        checks++;
        if (wbs_cyc_o !== 4'b0000 || wbm_err_o !== 1'b0 || wbm_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_next cyc=%b err=%b ack=%b expected 0000 0 0", wbs_cyc_o, wbm_err_o, wbm_ack_o);
        end
        test_read;
    endtask

    task automatic test_reset_mid;
        tick;
        adr = 32'h1000_0000; cyc = 1'b1; stb = 1'b1;
        tick;
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 4'b0010) begin
            failures++;
            $display("FAIL rstmid_active stb=%b expected 0010", wbs_stb_o);
        end
        tick;
        rst = 1'b1;
        tick;
        @(negedge clk);
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs ack=%b err=%b dat=%h cyc=%b stb=%b expected all 0",
                     wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o);
        end
        tick;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; man_ack = 4'b0010;
        @(negedge clk);
        checks++;
        if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_late_ack ack=%b err=%b expected 0 0", wbm_ack_o, wbm_err_o);
        end
        tick;
        man_ack = '0;
        test_read;
    endtask

    initial begin
        test_reset;
        test_read;
        test_back_to_back;
        test_overlap;
        test_unmapped;
        test_timeout;
        test_cyc_drop;
        test_reset_mid;
        tick;
        tick;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover pending=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
